// File: rtl/surf_event_merger.sv
// Frame-granular round-robin merge of NSURF byte streams into one stream.
// Define SURF_MERGE_HEADER_EN to emit a {4'hA,0,g} header beat ahead of each frame.
module surf_event_merger #(
  parameter int          NSURF          = 7,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096,
  parameter logic [7:0]  ERR_BYTE       = 8'hFF
) (
  input  logic                 sysclk_i,
  input  logic                 sysclk_rstn_i,
  input  logic [8*NSURF-1:0]   s_tdata,
  input  logic [NSURF-1:0]     s_tvalid,
  output logic [NSURF-1:0]     s_tready,
  input  logic [NSURF-1:0]     s_tlast,
  input  logic [NSURF-1:0]     enable_i,
  output logic [7:0]           m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic [2:0]           m_tuser,
  output logic [31:0]          frame_count_o,
  output logic [15:0]          timeout_count_o,
  output logic                 timeout_o
);
  typedef enum logic [1:0] {IDLE, HDR, DATA, FLUSH} state_t;

  localparam logic [3:0] NS4  = 4'(NSURF);
  localparam logic [2:0] LAST = 3'(NSURF - 1);

  state_t      state, state_n;
  logic [2:0]  grant, rr_ptr, winner, grant_inc;
  logic [3:0]  idx;
  logic        found, drain, drain_n;
  logic [15:0] tmo_cnt;
  logic        beat_acc, acc_last, tmo_fire, flush_done;
  logic [NSURF-1:0] cand;
  logic [7:0]  s_data_a [NSURF];

  for (genvar k = 0; k < NSURF; k++) begin : g_unpack
    assign s_data_a[k] = s_tdata[8*k +: 8];
  end

  assign cand      = enable_i & s_tvalid;
  assign grant_inc = (grant == LAST) ? 3'd0 : grant + 3'd1;

  // First candidate at or above the pointer, wrapping modulo NSURF.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    idx    = '0;
    for (int i = 0; i < NSURF; i++) begin
      idx = {1'b0, rr_ptr} + 4'(i);
      if (idx >= NS4) idx = idx - NS4;
      if (!found && cand[idx[2:0]]) begin
        found  = 1'b1;
        winner = idx[2:0];
      end
    end
  end

  always_comb begin
    state_n    = state;
    drain_n    = drain;
    s_tready   = '0;
    m_tdata    = '0;
    m_tvalid   = 1'b0;
    m_tlast    = 1'b0;
    m_tuser    = grant;
    beat_acc   = 1'b0;
    acc_last   = 1'b0;
    tmo_fire   = 1'b0;
    flush_done = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
`ifdef SURF_MERGE_HEADER_EN
          state_n = HDR;
`else
          state_n = DATA;
`endif
        end
      end
`ifdef SURF_MERGE_HEADER_EN
      HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = {4'hA, 1'b0, grant};
        if (m_tready) state_n = DATA;
      end
`endif
      DATA: begin
        m_tdata         = s_data_a[grant];
        m_tvalid        = s_tvalid[grant];
        m_tlast         = s_tlast[grant];
        s_tready[grant] = m_tready;
        beat_acc        = s_tvalid[grant] && m_tready;
        if (beat_acc && s_tlast[grant]) begin
          acc_last = 1'b1;
          state_n  = IDLE;
        end else if (!s_tvalid[grant] && tmo_cnt == TIMEOUT_CYCLES - 16'd1) begin
          tmo_fire = 1'b1;
          drain_n  = 1'b0;
          state_n  = FLUSH;
        end
      end
      FLUSH: begin
        // Terminate downstream with the error byte first, then swallow the source tail.
        if (!drain) begin
          m_tvalid = 1'b1;
          m_tdata  = ERR_BYTE;
          m_tlast  = 1'b1;
          if (m_tready) drain_n = 1'b1;
        end else begin
          s_tready[grant] = 1'b1;
          if (s_tvalid[grant] && s_tlast[grant]) begin
            flush_done = 1'b1;
            state_n    = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sysclk_i) begin
    if (!sysclk_rstn_i) begin
      state           <= IDLE;
      drain           <= 1'b0;
      grant           <= '0;
      rr_ptr          <= '0;
      tmo_cnt         <= '0;
      frame_count_o   <= '0;
      timeout_count_o <= '0;
      timeout_o       <= 1'b0;
    end else begin
      state     <= state_n;
      drain     <= drain_n;
      timeout_o <= tmo_fire;
      if (state == IDLE && found) grant <= winner;
      if (acc_last || flush_done) rr_ptr <= grant_inc;
      if (acc_last) frame_count_o <= frame_count_o + 32'd1;
      if (tmo_fire && timeout_count_o != 16'hFFFF)
        timeout_count_o <= timeout_count_o + 16'd1;
      // Only source silence counts; downstream backpressure holds the count.
      if (state != DATA || beat_acc) tmo_cnt <= '0;
      else if (!s_tvalid[grant])     tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_surf_event_merger.sv
// Randomized bench for surf_event_merger against a frame-level round-robin model.
module tb_surf_event_merger;
  localparam int NSURF = 7;
  localparam int TMO   = 4096;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;
  } beat_t;

  logic               clk = 1'b0;
  logic               rstn;
  logic [8*NSURF-1:0] s_tdata;
  logic [NSURF-1:0]   s_tvalid, s_tready, s_tlast, enable_i;
  logic [7:0]         m_tdata;
  logic               m_tvalid, m_tready, m_tlast, timeout_o;
  logic [2:0]         m_tuser;
  logic [31:0]        frame_count_o;
  logic [15:0]        timeout_count_o;

  surf_event_merger #(.NSURF(NSURF), .TIMEOUT_CYCLES(16'd4096), .ERR_BYTE(8'hFF)) dut (
    .sysclk_i(clk), .sysclk_rstn_i(rstn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .enable_i(enable_i),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .frame_count_o(frame_count_o),
    .timeout_count_o(timeout_count_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  beat_t       srcq [NSURF][$];
  beat_t       modq [NSURF][$];
  logic [11:0] outq [$];
  logic [11:0] expq [$];
  int nvec = 0, nerr = 0;
  int mptr = 0, m_frames = 0, m_tmo = 0, pulses = 0;
  int rdy_mode = 0;
  bit hold_all = 0, rtog = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, update source/sink drive just after the edge.
  task automatic tick();
    bit acc [NSURF];
    beat_t b;
    @(negedge clk);
    if ((m_tvalid & m_tready) === 1'b1) outq.push_back({m_tuser, m_tlast, m_tdata});
    if (timeout_o === 1'b1) pulses++;
    for (int k = 0; k < NSURF; k++) acc[k] = ((s_tvalid[k] & s_tready[k]) === 1'b1);
    @(posedge clk); #1;
    for (int k = 0; k < NSURF; k++) begin
      if (acc[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
      if (hold_all) s_tvalid[k] = 1'b1;
      else if (srcq[k].size() > 0) begin
        b = srcq[k][0];
        if (b.gap > 0) begin
          s_tvalid[k] = 1'b0;
          b.gap--;
          srcq[k][0] = b;
        end else begin
          s_tvalid[k]       = 1'b1;
          s_tdata[8*k +: 8] = b.data;
          s_tlast[k]        = b.last;
        end
      end else s_tvalid[k] = 1'b0;
    end
    rtog = ~rtog;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = rtog;
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    hold_all = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_s_tready", 32'(s_tready), 0);
      chk("rst_m_tvalid", 32'(m_tvalid), 0);
      chk("rst_frame_cnt", frame_count_o, 0);
      chk("rst_tmo_cnt", 32'(timeout_count_o), 0);
      chk("rst_tmo_pulse", 32'(timeout_o), 0);
    end
    rstn = 1'b1;
    hold_all = 0;
    s_tvalid = '0;
    mptr = 0; m_frames = 0; m_tmo = 0; pulses = 0;
    outq.delete();
  endtask

  task automatic add_frame(input int k, input int len, input int gmax,
                           input int stall_at, input int stall_gap, input bit seq);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = seq ? 8'(i + 1) : 8'($urandom_range(0, 255));
      b.last = (i == len - 1);
      b.gap  = (i == 0) ? 0 : (i == stall_at) ? stall_gap : int'($urandom_range(0, gmax));
      srcq[k].push_back(b);
      modq[k].push_back(b);
    end
  endtask

  // Whole frames in round-robin order; a source silence of TMO cycles turns the
  // rest of the frame into a single FF/tlast beat.
  task automatic model_drain(input logic [NSURF-1:0] en, input int max_frames);
    beat_t b;
    int k;
    bit ab;
    for (int f = 0; f < max_frames; f++) begin
      k = -1;
      for (int i = 0; i < NSURF; i++) begin
        int c;
        c = (mptr + i) % NSURF;
        if (k < 0 && en[c] && modq[c].size() > 0) k = c;
      end
      if (k < 0) break;
`ifdef SURF_MERGE_HEADER_EN
      expq.push_back({3'(k), 1'b0, 8'hA0 | 8'(k)});
`endif
      ab = 0;
      do begin
        b = modq[k].pop_front();
        if (!ab && b.gap >= TMO) begin
          ab = 1;
          expq.push_back({3'(k), 1'b1, 8'hFF});
        end
        if (!ab) expq.push_back({3'(k), b.last, b.data});
      end while (!b.last);
      if (ab) m_tmo++; else m_frames++;
      mptr = (k + 1) % NSURF;
    end
  endtask

  task automatic run_check(input string tag, input int budget);
    int n, c;
    n = expq.size();
    c = 0;
    while (outq.size() < n && c < budget) begin tick(); c++; end
    chk({tag, "_done"}, 32'(outq.size() >= n), 1);
    repeat (6) tick();
    chk({tag, "_len"}, 32'(outq.size()), 32'(n));
    for (int i = 0; i < n && i < outq.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 32'(outq[i]), 32'(expq[i]));
    chk({tag, "_frames"}, frame_count_o, 32'(m_frames));
    chk({tag, "_tmo_cnt"}, 32'(timeout_count_o), 32'(m_tmo));
    chk({tag, "_tmo_pulses"}, 32'(pulses), 32'(m_tmo));
    outq.delete();
    expq.delete();
  endtask

  initial begin
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; enable_i = '1; m_tready = 1'b1;
    do_reset();

    // Single 4-byte frame from SURF2.
    rdy_mode = 0;
    add_frame(2, 4, 0, -1, 0, 1);
    model_drain('1, 99);
    run_check("surf2", 200);

    // Simultaneous 0/3/6, two frames each, from pointer 0 (wraps back to 0).
    do_reset();
    for (int r = 0; r < 2; r++) begin
      add_frame(0, 2, 0, -1, 0, 0);
      add_frame(3, 2, 0, -1, 0, 0);
      add_frame(6, 2, 0, -1, 0, 0);
    end
    model_drain('1, 99);
    run_check("rr036", 400);
    for (int k = 0; k < NSURF; k++) add_frame(k, 3, 1, -1, 0, 0);
    rdy_mode = 2;
    model_drain('1, 99);
    run_check("rr_all", 800);

    // Silence one cycle short of the limit: no abort.
    rdy_mode = 2;
    add_frame(1, 5, 0, 2, TMO - 1, 0);
    model_drain('1, 99);
    run_check("tmo_edge", 20000);

    // Silence of exactly the limit: abort, tail dropped, next frame intact.
    rdy_mode = 0;
    add_frame(1, 5, 0, 2, TMO, 0);
    add_frame(1, 4, 0, -1, 0, 0);
    model_drain('1, 99);
    run_check("tmo_abort", 20000);

    // Backpressure toggling every cycle on an 8-byte frame.
    rdy_mode = 1;
    add_frame(4, 8, 0, -1, 0, 1);
    model_drain('1, 99);
    run_check("toggle", 400);

    // Disable SURF5 mid-frame: its frame finishes, later ones are held off.
    rdy_mode = 1;
    add_frame(5, 6, 2, -1, 0, 0);
    model_drain('1, 1);
    for (int c = 0; c < 200 && outq.size() == 0; c++) tick();
    enable_i[5] = 1'b0;
    add_frame(0, 3, 1, -1, 0, 0);
    add_frame(0, 2, 1, -1, 0, 0);
    add_frame(5, 3, 0, -1, 0, 0);
    model_drain(7'b1011111, 99);
    run_check("en5", 800);
    chk("en5_held", 32'(srcq[5].size()), 3);
    srcq[5].delete();
    modq[5].delete();
    tick();
    enable_i = '1;

    // Random source sets, lengths, gaps and backpressure.
    rdy_mode = 2;
    for (int it = 0; it < 15; it++) begin
      logic [NSURF-1:0] mask;
      mask = NSURF'($urandom_range(1, (1 << NSURF) - 1));
      for (int k = 0; k < NSURF; k++)
        if (mask[k]) begin
          add_frame(k, int'($urandom_range(1, 6)), 3, -1, 0, 0);
          if ($urandom_range(0, 1) == 1) add_frame(k, int'($urandom_range(1, 6)), 3, -1, 0, 0);
        end
      model_drain('1, 99);
      run_check($sformatf("rnd%0d", it), 3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
